muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath.

---
 rtl/muldiv_unit.sv | 117 +++++++++++
 tb/tb_muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividend;
  logic               is_div, neg_q, neg_r, div_zero;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // acc holds the running product for multiply, or {remainder, quotient/dividend} for divide
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    prod_fix  = neg_q ? -acc : acc;
    res_hi    = prod_fix[2*WIDTH-1:WIDTH];
    res_lo    = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = dividend;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            state    <= CALC;
            count    <= '0;
            busy     <= 1'b1;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
            dividend <= a;
            opnd     <= op[1] ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          end
        end
        CALC: begin
          if (is_div) begin
            if (div_diff[WIDTH]) acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, "_hi"}, hi, e[63:32]);
        check({n, "_lo"}, lo, e[31:0]);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n, bc;
    logic [31:0] h0, l0;
    logic moved;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back({eh, el});
    name_q.push_back(name);
    h0 = hi; l0 = lo;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    bc = busy ? 1 : 0;
    n = 0;
    moved = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
      if (!done && (hi !== h0 || lo !== l0)) moved = 1'b1;
    end
    check({name, "_latency"}, n, 33);
    check({name, "_busy_cycles"}, bc, 33);
    check({name, "_hold"}, {31'd0, moved}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // both move-to writes in one cycle
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_hi", hi, 32'hCAFEF00D);
    check("mthi_mtlo_lo", lo, 32'hCAFEF00D);

    // Test 1: reset in the middle of CALC abandons the operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_5d0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_m5d0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_min_dm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

    // Test 8: contention while busy
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    exp_q.push_back({32'd0, 32'd42});
    name_q.push_back("contend_6x7");
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    dcount = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("contend_done_pulses", dcount, 1);
    check("contend_hi_after", hi, 32'd0);
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_idle_lo", lo, 32'h0000ABCD);
    check("mtlo_idle_hi", hi, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
